// File: rtl/sound_pkg.sv
// Shared types and defaults for the melody sequencer and its helpers.
package sound_pkg;

   typedef enum logic [1:0] {IDLE, FETCH, PLAY} state_t;

   localparam int DUTY_MID_DEFAULT = 50;
   localparam int DUTY_AMP_DEFAULT = 25;
   localparam int HP_W_DEFAULT     = 22;
   localparam int DUR_W_DEFAULT    = 10;

   // Builds a {half_period, duration} entry; freq_hz of 0 gives a rest.
   function automatic logic [HP_W_DEFAULT+DUR_W_DEFAULT-1:0] make_entry(
      input int unsigned sys_freq_hz,
      input int unsigned freq_hz,
      input int unsigned dur
   );
      logic [HP_W_DEFAULT-1:0] hp;
      hp = (freq_hz == 0) ? '0 : HP_W_DEFAULT'(sys_freq_hz / (2 * freq_hz));
      return {hp, DUR_W_DEFAULT'(dur)};
   endfunction

endpackage

// File: rtl/melody_sequencer_if.sv
// Control, note-table write and audio output bundle of the melody sequencer.
interface melody_sequencer_if #(
   parameter int ADDR_W = 5,
   parameter int HP_W   = 22,
   parameter int DUR_W  = 10
);
   logic                    wr_en;
   logic [ADDR_W-1:0]       wr_addr;
   logic [HP_W+DUR_W-1:0]   wr_data;
   logic                    start;
   logic                    stop;
   logic [ADDR_W:0]         song_len;
   logic                    loop;
   logic                    playing;
   logic [ADDR_W-1:0]       note_idx;
   logic                    tone;
   logic                    done;
   logic [6:0]              duty_cycle;

   modport master (
      output wr_en, wr_addr, wr_data, start, stop, song_len, loop,
      input  playing, note_idx, tone, done, duty_cycle
   );

   modport slave (
      input  wr_en, wr_addr, wr_data, start, stop, song_len, loop,
      output playing, note_idx, tone, done, duty_cycle
   );
endinterface

// File: rtl/tone_gen.sv
// Square-wave generator: toggles every hp enabled cycles, silent when hp is 0.
module tone_gen #(
   parameter int HP_W = 22
) (
   input  logic            clk,
   input  logic            reset,
   input  logic            clear,
   input  logic            en,
   input  logic [HP_W-1:0] hp,
   output logic            tone
);

   logic [HP_W-1:0] cnt;

   always_ff @(posedge clk) begin
      if (reset || clear) begin
         cnt  <= '0;
         tone <= 1'b0;
      end else if (en && (hp != '0)) begin
         if (cnt == hp - HP_W'(1)) begin
            cnt  <= '0;
            tone <= ~tone;
         end else begin
            cnt <= cnt + HP_W'(1);
         end
      end
   end

endmodule

// File: rtl/melody_sequencer.sv
// Note-table melody player: steps through {half_period, duration} entries at a tick rate.
//   state | meaning
//   IDLE  | table writable, waiting for a valid start
//   FETCH | synchronous read of mem[idx]; tone and timers cleared
//   PLAY  | tone running, tick timer counting toward the note duration
module melody_sequencer
   import sound_pkg::*;
#(
   parameter int SYS_FREQ_HZ = 100_000_000,
   parameter int TICK_HZ     = 1000,
   parameter int DEPTH       = 32,
   parameter int ADDR_W      = 5,
   parameter int HP_W        = HP_W_DEFAULT,
   parameter int DUR_W       = DUR_W_DEFAULT,
   parameter int DUTY_MID    = DUTY_MID_DEFAULT,
   parameter int DUTY_AMP    = DUTY_AMP_DEFAULT
) (
   input logic               clk,
   input logic               reset,
   melody_sequencer_if.slave bus
);

   localparam int CPT     = SYS_FREQ_HZ / TICK_HZ;
   localparam int TICK_W  = $clog2(CPT);
   localparam int ENTRY_W = HP_W + DUR_W;

   state_t              state, state_next;
   logic [ENTRY_W-1:0]  mem [DEPTH];
   logic [ENTRY_W-1:0]  entry;
   logic [HP_W-1:0]     hp;
   logic [DUR_W-1:0]    dur;
   logic [ADDR_W-1:0]   idx, idx_next;
   logic [ADDR_W:0]     len_q;
   logic                loop_q;
   logic [TICK_W-1:0]   tick_ctr;
   logic [DUR_W-1:0]    tick_cnt;
   logic                done_q, done_next;
   logic                start_ok, note_end, last_note;
   logic                tone_int;
   logic [6:0]          duty;

   assign hp  = entry[ENTRY_W-1:DUR_W];
   assign dur = entry[DUR_W-1:0];

   assign start_ok  = bus.start && (bus.song_len != '0) &&
                      (bus.song_len <= (ADDR_W+1)'(DEPTH));
   // The last tick completes on the terminal count of the tick timer itself.
   assign note_end  = (dur == '0) ||
                      ((tick_ctr == '0) && (tick_cnt == dur - DUR_W'(1)));
   assign last_note = (({1'b0, idx} + (ADDR_W+1)'(1)) >= len_q);

   always_ff @(posedge clk) begin
      if ((state == IDLE) && bus.wr_en) mem[bus.wr_addr] <= bus.wr_data;
      if (state == FETCH) entry <= mem[idx];
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state  <= IDLE;
         idx    <= '0;
         len_q  <= '0;
         loop_q <= 1'b0;
         done_q <= 1'b0;
      end else begin
         state  <= state_next;
         idx    <= idx_next;
         done_q <= done_next;
         if ((state == IDLE) && start_ok) begin
            len_q  <= bus.song_len;
            loop_q <= bus.loop;
         end
      end
   end

   always_comb begin
      state_next = state;
      idx_next   = idx;
      done_next  = 1'b0;
      case (state)
         IDLE: begin
            if (start_ok) begin
               state_next = FETCH;
               idx_next   = '0;
            end
         end
         FETCH: state_next = PLAY;
         PLAY: begin
            if (note_end) begin
               if (!last_note) begin
                  idx_next   = idx + ADDR_W'(1);
                  state_next = FETCH;
               end else if (loop_q) begin
                  idx_next   = '0;
                  state_next = FETCH;
               end else begin
                  state_next = IDLE;
                  done_next  = 1'b1;
               end
            end
         end
         default: state_next = IDLE;
      endcase
      if (bus.stop) begin
         state_next = IDLE;
         idx_next   = idx;
         done_next  = 1'b0;
      end
   end

   // Tick timer counts down from CPT-1; each terminal count is one elapsed tick.
   always_ff @(posedge clk) begin
      if (reset || (state == FETCH)) begin
         tick_ctr <= TICK_W'(CPT - 1);
         tick_cnt <= '0;
      end else if (state == PLAY) begin
         if (tick_ctr == '0) begin
            tick_ctr <= TICK_W'(CPT - 1);
            tick_cnt <= tick_cnt + DUR_W'(1);
         end else begin
            tick_ctr <= tick_ctr - TICK_W'(1);
         end
      end
   end

   // Clearing whenever PLAY is not next keeps tone low through FETCH and IDLE.
   tone_gen #(.HP_W(HP_W)) u_tone_gen (
      .clk   (clk),
      .reset (reset),
      .clear (state_next != PLAY),
      .en    (state == PLAY),
      .hp    (hp),
      .tone  (tone_int)
   );

   always_comb begin
      duty = 7'(DUTY_MID);
      if (state == PLAY) begin
         if (tone_int)        duty = 7'(DUTY_MID + DUTY_AMP);
         else if (hp != '0)   duty = 7'(DUTY_MID - DUTY_AMP);
      end
   end

   assign bus.playing    = (state != IDLE);
   assign bus.note_idx   = idx;
   assign bus.tone       = tone_int;
   assign bus.done       = done_q;
   assign bus.duty_cycle = duty;

endmodule

// File: doc/melody_sequencer.md
# melody_sequencer

Parametrised melody player for the sound controller. It holds a writable note table and steps through it at a programmable tick rate. For each note it produces a square-wave tone, and it emits a duty-cycle word for the existing `PWMSerializer`. Compared with the fixed single-tune player, it adds:
- a runtime-loadable song
- rests and zero-length entries
- start, stop and loop control
- done signalling
- a configurable amplitude

## Interface
- `SYS_FREQ_HZ`, 100_000_000: system clock frequency.
- `TICK_HZ`, 1000: duration unit rate; one tick is SYS_FREQ_HZ/TICK_HZ cycles, and this must be an integer ≥ 2.
- `DEPTH`, 32: note table entries.
- `ADDR_W`, 5: equals clog2(DEPTH).
- `HP_W`, 22: half-period field width in cycles. A value of 0 means rest.
- `DUR_W`, 10: duration field width in ticks.
- `DUTY_MID`, 50: silent duty value.
- `DUTY_AMP`, 25: tone swing around DUTY_MID.
- `clk` in 1: system clock.
- `reset` in 1: synchronous, active-high reset.
- `wr_en` in 1: note table write strobe.
- `wr_addr` in ADDR_W: write address.
- `wr_data` in HP_W+DUR_W: {half_period, duration}.
- `start` in 1: begin playback from entry 0.
- `stop` in 1: abort playback.
- `song_len` in ADDR_W+1: number of entries to play, 1..DEPTH; sampled on start.
- `loop` in 1: restart after the last entry; sampled on start.
- `playing` out 1: high whenever the FSM is not in IDLE.
- `note_idx` out ADDR_W: index of the current entry.
- `tone` out 1: square wave of the current note.
- `done` out 1: one-cycle pulse when a non-looping song ends.
- `duty_cycle` out 7: drive to `PWMSerializer`.

## Operation
The FSM has three states: IDLE, FETCH and PLAY.

**IDLE**
- `wr_en` writes `wr_data` to `mem[wr_addr]`. Writes are ignored in any other state.
- `start` is accepted only when `song_len` is in 1..DEPTH; otherwise it is ignored.
- On an accepted start: latch `song_len` and `loop`, set idx=0, go to FETCH.

**FETCH**
- The memory read is synchronous. Read `mem[idx]`, and next cycle latch hp and dur.
- Clear the tone, half-period counter, tick counter and tick count, then go to PLAY.

**PLAY**
- When hp≠0, `tone` toggles every hp cycles; the first toggle occurs hp cycles after PLAY entry.
- When hp=0 (rest), `tone` is held at 0.
- The tick counter wraps at SYS_FREQ_HZ/TICK_HZ−1, and each wrap increments the tick count.
- A note ends on the cycle the tick count reaches dur. A note with dur=0 ends on its first PLAY cycle.
- At note end:
  - If idx < len−1: idx+1, go to FETCH.
  - Else if loop: idx=0, go to FETCH.
  - Else: pulse `done`, go to IDLE.

**Stop and reset**
- `stop` in any state: go to IDLE next cycle with `tone` cleared. No `done` pulse is produced.
- `stop` takes priority over `start` and over a note end in the same cycle.
- `start` while playing is ignored. A restart requires stop, then start.

**Outputs**
- `duty_cycle` = DUTY_MID+DUTY_AMP when PLAY & `tone`.
- `duty_cycle` = DUTY_MID−DUTY_AMP when PLAY & !`tone` & hp≠0.
- Otherwise `duty_cycle` = DUTY_MID.
- All arithmetic is unsigned. Counters are sized so that no overflow occurs at maximum field values.

## Timing
- Reset values: state IDLE, `playing`=0, `note_idx`=0, `tone`=0, `done`=0, `duty_cycle`=DUTY_MID. Memory contents are not reset.
- Start accepted at cycle T:
  - FETCH at T+1.
  - PLAY at T+2; `playing`=1 from T+1.
- For a note occupying PLAY from cycle P:
  - It ends at P + dur·(SYS_FREQ_HZ/TICK_HZ) − 1.
  - FETCH follows next cycle.
  - Inter-note overhead is 1 cycle (FETCH).
- `done` is asserted on the cycle IDLE is entered. `playing` falls on the same cycle.
- A write and a start in the same IDLE cycle: the write completes and playback reads the new data.
- Reset mid-playback returns all outputs to their reset values on the next cycle.

## Structure
- Package `sound_pkg` holds:
  - the state enum `{IDLE, FETCH, PLAY}`
  - DUTY_MID and DUTY_AMP defaults
  - a function building an entry from a frequency and a duration: hp = SYS_FREQ_HZ/(2·freq).
- Sub-module `tone_gen`: half-period counter plus toggle, with a clear input and an hp input.
- Memory is an inferred synchronous-read array.

## Test plan
Bench parameters: SYS_FREQ_HZ=1000, TICK_HZ=100, giving 10 cycles per tick.

1. Load {hp=3,dur=2}, {hp=0,dur=1}; song_len=2, loop=0.
   - Entry 0: `tone` period 6 cycles for 20 cycles.
   - Entry 1: `duty_cycle` 50 for 10 cycles.
   - `done` pulses once, at T+2+20+1+10−1+1.
2. Same song with loop=1:
   - `note_idx` sequence 0,1,0,1…
   - `done` never asserts.
   - `stop` returns to IDLE next cycle with `duty_cycle`=50.
3. Entry {hp=5,dur=0} between two notes: skipped after 2 cycles (FETCH plus one PLAY cycle), with no toggle.
4. Start with song_len=0 and with song_len=DEPTH+1: `playing` stays 0. A write while playing leaves memory unchanged, checked by readback on replay.
5. Stop and start in the same cycle during PLAY: goes to IDLE, start ignored. Reset asserted mid-note: all outputs at reset values next cycle.
6. `duty_cycle` follows `tone`: 75 when high, 25 when low, 50 during a rest.
